// File: rtl/load_store_unit.sv
// load_store_unit: turns core load/store requests into word accesses on a
// single-port data memory. Loads get byte-lane extraction and sign or zero
// extension. Byte and half stores read the word first, merge the new lane and
// then write the whole word back.
// Optional feature macro: LSU_BOUNDS_CHECK_EN. When it is defined, any request
// whose word index req_addr[31:2] is >= MEM_WORDS is rejected without a memory
// access. When it is undefined, the full address goes to the memory unchecked.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // A memory of zero words cannot be attached; stop at elaboration instead.
  generate
    if (MEM_WORDS < 1) begin : g_bad_mem_words
      $error("load_store_unit: MEM_WORDS must be at least 1");
    end
  endgenerate

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic        store_reg;
  logic [15:0] store_low_reg;   // only the low half is needed for SB/SH merges
  logic        err_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem_wdata_reg;

  logic        req_err;
  logic        req_is_sw;
  logic [31:0] load_value;
  logic [31:0] merged_word;
  logic [3:0]  lane_hit;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign req_is_sw = req_store && (req_funct3 == F3_W);

  // Classify an incoming request as legal or rejected.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = (req_addr[1:0] != 2'b00);
      F3_BU:   req_err = req_store;
      F3_HU:   req_err = req_store | req_addr[0];
      default: req_err = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    if (req_addr[31:2] >= 30'(MEM_WORDS)) begin
      req_err = 1'b1;
    end
`endif
  end

  // Pick the addressed byte and half out of the word returned by the memory.
  always_comb begin
    sel_byte = 8'h00;
    case (addr_reg[1:0])
      2'd0:    sel_byte = mem_read_data[7:0];
      2'd1:    sel_byte = mem_read_data[15:8];
      2'd2:    sel_byte = mem_read_data[23:16];
      default: sel_byte = mem_read_data[31:24];
    endcase
    sel_half = addr_reg[1] ? mem_read_data[31:16] : mem_read_data[15:0];
  end

  // Extend the selected lane to the architectural load result.
  always_comb begin
    load_value = mem_read_data;
    case (funct3_reg)
      F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
      F3_BU:   load_value = {24'h000000, sel_byte};
      F3_HU:   load_value = {16'h0000, sel_half};
      default: load_value = mem_read_data;
    endcase
  end

  // Per byte lane: take new store data when this lane is targeted, otherwise
  // keep what the memory returned. funct3[0] distinguishes half from byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_hit[gi] = funct3_reg[0] ? (addr_reg[1] == LANE[1])
                                          : (addr_reg[1:0] == LANE);
      assign merged_word[8*gi +: 8] =
        lane_hit[gi] ? (funct3_reg[0] ? store_low_reg[8*(gi%2) +: 8]
                                      : store_low_reg[7:0])
                     : mem_read_data[8*gi +: 8];
    end
  endgenerate

  // State register; reset forces IDLE at once so a pending write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection and the state-decoded handshake/strobe outputs.
  always_comb begin
    state_next       = state_reg;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_is_sw) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        state_next = store_reg ? WRITE : RESP;
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        state_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch, load result and write-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= 32'h0;
      funct3_reg    <= 3'b000;
      store_reg     <= 1'b0;
      store_low_reg <= 16'h0;
      err_reg       <= 1'b0;
      rdata_reg     <= 32'h0;
      mem_wdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            addr_reg      <= req_addr;
            funct3_reg    <= req_funct3;
            store_reg     <= req_store;
            store_low_reg <= req_wdata[15:0];
            err_reg       <= req_err;
            rdata_reg     <= 32'h0;
            if (!req_err && req_is_sw) begin
              mem_wdata_reg <= req_wdata;
            end
          end
        end
        READ: begin
          if (store_reg) begin
            mem_wdata_reg <= merged_word;
          end else begin
            rdata_reg <= load_value;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_address    = addr_reg;
  assign mem_write_data = mem_wdata_reg;
  assign resp_error     = resp_valid & err_reg;
  assign resp_rdata     = resp_valid ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a behavioural word memory, a
// scoreboard queue of expected responses and a per-transaction monitor.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_store        (req_store),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: 1024 words, combinational read, write at posedge.
  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  assign mem_read_data = mem[mem_address[11:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[11:2]] <= mem_write_data;
    end else if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_data;
  } exp_t;

  exp_t sb_q[$];

  int checks;
  int errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = byte_addr[11:2];
    pre_data = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Drive one request, push its expectation, monitor until resp_valid.
  task automatic run_req(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int we_cyc, input logic [31:0] exp_wd);
    exp_t e;
    exp_t p;
    int cyc;
    int we_cnt;
    int we_c;
    logic [31:0] we_d;
    logic got;
    logic [31:0] rd;
    logic er;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.lat     = lat;
    e.we_cnt  = (we_cyc != 0) ? 1 : 0;
    e.we_cyc  = we_cyc;
    e.we_data = exp_wd;
    sb_q.push_back(e);

    @(negedge clk);
    check_eq($sformatf("%s_ready_idle", name), {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    cyc = 0; we_cnt = 0; we_c = 0; we_d = 32'h0; got = 1'b0; rd = 32'h0; er = 1'b0;
    while (!got && cyc < 8) begin
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        check_eq($sformatf("%s_ready_busy", name), {31'h0, req_ready}, 32'h0);
      end
      if (mem_write_enable) begin
        we_cnt++;
        if (we_cnt == 1) begin
          we_c = cyc;
          we_d = mem_write_data;
        end
      end
      if (resp_valid) begin
        got = 1'b1;
        rd  = resp_rdata;
        er  = resp_error;
      end
    end
    if (!got) begin
      check_eq($sformatf("%s_timeout", name), 32'h0, 32'h1);
    end

    p = sb_q.pop_front();
    check_eq($sformatf("%s_rdata", name), rd, p.rdata);
    check_eq($sformatf("%s_error", name), {31'h0, er}, {31'h0, p.err});
    check_eq($sformatf("%s_latency", name), 32'(cyc), 32'(p.lat));
    check_eq($sformatf("%s_we_count", name), 32'(we_cnt), 32'(p.we_cnt));
    if (p.we_cnt != 0) begin
      check_eq($sformatf("%s_we_cycle", name), 32'(we_c), 32'(p.we_cyc));
      check_eq($sformatf("%s_we_data", name), we_d, p.we_data);
    end
    $display("txn %s lat=%0d rdata=%h err=%0d we=%0d", name, cyc, rd, er, we_cnt);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pre_we     = 1'b0;
    pre_idx    = 10'h0;
    pre_data   = 32'h0;

    // Memory image loaded while the unit is held in reset.
    preload(32'h12C, 32'hDEADBEEF);
    preload(32'h130, 32'h00000000);
    preload(32'h400, 32'hCAFEF00D);
    preload(32'h000, 32'h00000000);

    // req_valid during reset must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h12C;
    req_funct3 = 3'b010;
    @(negedge clk);
    check_eq("rst_req_ready",  {31'h0, req_ready},        32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid},       32'h0);
    check_eq("rst_resp_rdata", resp_rdata,                32'h0);
    check_eq("rst_resp_error", {31'h0, resp_error},       32'h0);
    check_eq("rst_mem_addr",   mem_address,               32'h0);
    check_eq("rst_mem_wdata",  mem_write_data,            32'h0);
    check_eq("rst_mem_we",     {31'h0, mem_write_enable}, 32'h0);
    req_valid = 1'b0;
    rst = 1'b0;

    // Loads from the word 0xDEADBEEF at 0x12C.
    run_req("lb_12f",  1'b0, 3'b000, 32'h12F, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 32'h0);
    run_req("lbu_12f", 1'b0, 3'b100, 32'h12F, 32'h0, 32'h000000DE, 1'b0, 2, 0, 32'h0);
    run_req("lhu_12e", 1'b0, 3'b101, 32'h12E, 32'h0, 32'h0000DEAD, 1'b0, 2, 0, 32'h0);
    run_req("lh_12c",  1'b0, 3'b001, 32'h12C, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 0, 32'h0);
    run_req("lb_12c",  1'b0, 3'b000, 32'h12C, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0, 32'h0);
    run_req("lbu_12d", 1'b0, 3'b100, 32'h12D, 32'h0, 32'h000000BE, 1'b0, 2, 0, 32'h0);
    run_req("lw_12c",  1'b0, 3'b010, 32'h12C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);

    // Sub-word and word stores.
    run_req("sb_12d", 1'b1, 3'b000, 32'h12D, 32'h000000AA, 32'h0, 1'b0, 3, 2, 32'hDEADAAEF);
    check_eq("sb_12d_mem", mem[32'h12C >> 2], 32'hDEADAAEF);
    preload(32'h12C, 32'hDEADBEEF);
    run_req("sh_12e", 1'b1, 3'b001, 32'h12E, 32'h00001234, 32'h0, 1'b0, 3, 2, 32'h1234BEEF);
    check_eq("sh_12e_mem", mem[32'h12C >> 2], 32'h1234BEEF);
    run_req("sw_130", 1'b1, 3'b010, 32'h130, 32'h12345678, 32'h0, 1'b0, 2, 1, 32'h12345678);
    check_eq("sw_130_mem", mem[32'h130 >> 2], 32'h12345678);
    preload(32'h12C, 32'hDEADBEEF);

    // Rejected requests: response in cycle 1, no write.
    run_req("err_lw_12d", 1'b0, 3'b010, 32'h12D, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
    run_req("err_sh_131", 1'b1, 3'b001, 32'h131, 32'h0000FFFF, 32'h0, 1'b1, 1, 0, 32'h0);
    run_req("err_f3_011", 1'b0, 3'b011, 32'h12C, 32'h0,        32'h0, 1'b1, 1, 0, 32'h0);
    run_req("err_sbu",    1'b1, 3'b100, 32'h12C, 32'h000000FF, 32'h0, 1'b1, 1, 0, 32'h0);
    check_eq("err_mem_intact", mem[32'h12C >> 2], 32'hDEADBEEF);

`ifdef LSU_BOUNDS_CHECK_EN
    run_req("lw_400_oob", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
`else
    run_req("lw_400", 1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 32'h0);
`endif

    // SB aborted by reset during its WRITE cycle.
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h12D;
    req_wdata  = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check_eq("abort_we_before_rst", {31'h0, mem_write_enable}, 32'h1);
    #2 rst = 1'b1;
    #1 check_eq("abort_we_async_drop", {31'h0, mem_write_enable}, 32'h0);
    check_eq("abort_ready_in_rst", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("abort_no_resp_%0d", i), {31'h0, resp_valid}, 32'h0);
    end
    check_eq("abort_ready", {31'h0, req_ready}, 32'h1);
    check_eq("abort_mem_intact", mem[32'h12C >> 2], 32'hDEADBEEF);
    check_eq("abort_sb_empty", 32'(sb_q.size()), 32'h0);
    $display("txn abort_sb_12d rst during WRITE mem=%h", mem[32'h12C >> 2]);

    // Unit resumes normally after the abort.
    run_req("lw_after_rst", 1'b0, 3'b010, 32'h12C, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the word-wide data-memory interface: turns core load/store requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW) into accesses on the single-port memory's address/write_data/write_enable/read_data bus. It performs byte-lane extraction and sign/zero extension for loads. Sub-word stores use read-modify-write, because the memory has only a whole-word write enable. It sits between the execute stage and the data memory.

## Interface
- MEM_WORDS, 256, number of 32-bit words in the attached memory; used by the bounds check.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/half used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_error  out  1  request rejected, valid with resp_valid.
- mem_address  out  32  byte address to memory; memory indexes by [31:2].
- mem_write_data  out  32  full word to write.
- mem_write_enable  out  1  word write strobe, sampled by memory at posedge.
- mem_read_data  in  32  combinational read of word at mem_address.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. A request with req_valid=1 is latched (addr, funct3, store, wdata), and the next state is chosen by request type:
  - Error: next state RESP with the error flag set.
  - SW: next state WRITE.
  - Any load, SB, SH: next state READ.
- Error conditions:
  - Illegal funct3: 011, 110, 111; also 100 or 101 with req_store=1.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Bounds violation (see Configuration).
- READ: mem_address=latched addr.
  - Load: result computed from mem_read_data, next state RESP.
  - SB/SH: merge register loaded, next state WRITE.
- Lane select uses addr[1:0], little-endian: byte k = bits [8k+7:8k]; half selected by addr[1].
- B/H loads sign-extend; BU/HU loads zero-extend; W passes the word through.
- Merge: replace the selected byte/half of the read word with req_wdata[7:0] / [15:0]; other lanes unchanged.
- WRITE: mem_write_enable=1 for exactly this one cycle, mem_write_data=merged word (SW: req_wdata), next state RESP.
- RESP: resp_valid=1, resp_rdata / resp_error driven, next state IDLE.
- Outside READ/WRITE, mem_address holds the last latched address and mem_write_data holds its last value. mem_write_enable=0 in every state except WRITE.
- Errored requests never issue a memory access.

## Timing
- Request accepted at edge 0.
- resp_valid high in cycle:
  - 2 for loads and SW.
  - 3 for SB/SH.
  - 1 for errors.
- Throughput: at most one outstanding request. req_ready is low from acceptance through RESP, and a new request is accepted no earlier than the cycle after RESP.
- resp_valid has no backpressure; the consumer must take it.
- Reset values:
  - req_ready=1 (IDLE).
  - resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_address=0, mem_write_data=0, mem_write_enable=0.
- Reset asserted mid-operation: state is forced to IDLE immediately and mem_write_enable drops asynchronously. A write pending in WRITE is not committed if rst rises before its edge. No response is produced for the aborted request.
- req_valid while rst is high is ignored.

## Configuration
- LSU_BOUNDS_CHECK_EN defined: a request with req_addr[31:2] >= MEM_WORDS is an error (resp_error=1, no access).
- LSU_BOUNDS_CHECK_EN undefined: no range check, the full address is passed through, and MEM_WORDS is unused.

## Test plan
- Memory word at 0x12C = 0xDEADBEEF.
  - LB 0x12F -> resp_rdata 0xFFFFFFDE in cycle 2.
  - LBU 0x12F -> 0x000000DE.
  - LHU 0x12E -> 0x0000DEAD.
  - LH 0x12C -> 0xFFFFBEEF.
- SB 0x12D with wdata 0x000000AA -> exactly one mem_write_enable pulse in cycle 2 with mem_write_data 0xDEADAAEF; resp_valid in cycle 3.
- SH 0x12E with 0x00001234 -> word becomes 0x1234BEEF. SW 0x130 with 0x12345678 -> write in cycle 1, word 0x12345678.
- Error requests, each -> resp_valid and resp_error in cycle 1, resp_rdata 0, mem_write_enable never asserted:
  - LW 0x12D.
  - SH 0x131.
  - funct3 011.
  - SBU (store with funct3 100).
- SB 0x12D with rst pulsed during the WRITE cycle -> no write, word still 0xDEADBEEF, req_ready=1, resp_valid=0.
- LW 0x400 with LSU_BOUNDS_CHECK_EN and MEM_WORDS=256 -> resp_error=1 with no access; without the macro -> normal read.
